bip_accumulator: RTL and testbench
==================================

Name: bip_accumulator

Overview:
- Instruction-driven accumulator stage that sits directly upstream of the 16-bit `alu`.
- Accepts one 16-bit BIP-I instruction per handshake and fetches operands from immediate or data memory.
- Drives the ALU's a/b/op inputs and registers the ALU's `data_out` back into the accumulator.
- Also performs accumulator stores to data memory.

Parameters:
DATA_W, 16, accumulator/ALU/memory data width
ADDR_W, 11, data memory address width (= instruction operand field width)
ALU_ADD, 1'b0, alu op encoding for addition
ALU_SUB, 1'b1, alu op encoding for subtraction

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous, active-low reset
instr_valid  in  1  instruction present on instr
instr_ready  out  1  block can accept an instruction
instr  in  16  [15:11] opcode, [10:0] operand (address or immediate)
alu_a  out  DATA_W  to alu.a, always = acc
alu_b  out  DATA_W  to alu.b, selected operand
alu_op  out  1  to alu.op
alu_result  in  DATA_W  from alu.data_out (combinational)
mem_addr  out  ADDR_W  data memory address
mem_rd  out  1  read strobe; mem_rdata valid the following cycle
mem_wr  out  1  write strobe, one cycle
mem_wdata  out  DATA_W  = acc
mem_rdata  in  DATA_W  synchronous-RAM read data
acc  out  DATA_W  accumulator value
acc_zero  out  1  acc == 0
done  out  1  one-cycle pulse, instruction retired

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, acc=0, latched opcode/operand=0.
  - done=0, mem_rd=0, mem_wr=0, mem_addr=0, alu_op=ALU_ADD, alu_b=0.
  - instr_ready=1, acc_zero=1.
  - Reset mid-operation aborts immediately: no mem_wr, no done, and acc returns to 0.
- Opcodes:
  - 00000 HLT/NOP: no change.
  - 00001 ST: mem[op] <= acc.
  - 00010 LD: acc <= mem[op].
  - 00011 LDI: acc <= sext(imm).
  - 00100 ADD: acc <= acc + mem[op].
  - 00101 ADDI: acc <= acc + sext(imm).
  - 00110 SUB: acc <= acc - mem[op].
  - 00111 SUBI: acc <= acc - sext(imm).
  - Any other opcode: executes as NOP, still pulses done.
- Immediate: 11-bit operand sign-extended to DATA_W (0x7FF -> 0xFFFF, 0x3FF -> 0x03FF).
- States:
  - IDLE: instr_ready=1. On instr_valid&instr_ready, latch instr. LD/ADD/SUB -> MEM; all others -> EXEC. instr_ready=0 outside IDLE; instr is ignored when not accepted.
  - MEM: mem_rd=1, mem_addr=operand. -> EXEC.
  - EXEC:
    - alu_b = mem_rdata for memory ops, sext(imm) otherwise.
    - alu_op = ALU_SUB for SUB/SUBI, else ALU_ADD.
    - ADD/ADDI/SUB/SUBI: acc <= alu_result at end of cycle.
    - LD/LDI: acc <= alu_b (ALU bypassed).
    - ST: mem_wr=1, mem_addr=operand, mem_wdata=acc.
    - -> DONE.
  - DONE: done=1 for exactly one cycle. -> IDLE.
- Latency, accept edge to done high:
  - immediate/ST/NOP: 2 cycles.
  - memory-read ops: 3 cycles.
  - Throughput: one instruction per 3 cycles (immediate) or per 4 cycles (memory read).
- acc is visible on the acc port the cycle done is high.
- Arithmetic:
  - Modulo 2^DATA_W; wrap-around is silent, with no carry or overflow flags.
  - acc_zero is combinational from acc.
- mem_rd and mem_wr are never both high. mem_addr holds the operand in MEM/EXEC and is 0 elsewhere.
- instr_valid held high continuously: the next instruction is accepted on the first IDLE cycle after DONE.

Test Plan:
- Reset: assert rst_n=0 mid-EXEC of an ST -> mem_wr never pulses, acc=0, instr_ready=1, acc_zero=1.
- LDI 5 then ADDI 3 -> acc=0x0005 then 0x0008; alu_op=0 in ADDI EXEC; done 2 cycles after each accept.
- LDI 5, SUBI 0x7FF (−1) -> acc=0x0006. Then SUBI 6 -> acc=0x0000, acc_zero=1.
- mem[0x10]=0xFFFF; LDI 1; ADD 0x10 -> mem_rd=1 with mem_addr=0x010 one cycle after accept; acc=0x0000 (wrap); done 3 cycles after accept.
- LDI 0x123; ST 0x20; LD 0x20 -> mem_wr single cycle, mem_wdata=0x0123 at addr 0x020; final acc=0x0123.
- Back-to-back with instr_valid always high, including opcode 11111 -> each accept spaced by latency+1 cycles; the illegal opcode leaves acc unchanged and pulses done.

Source files
------------

// File: rtl/bip_accumulator.sv
// BIP-I accumulator stage: fetches an operand from the immediate field or data memory,
// drives the external ALU, and writes the result (or a bypassed load) into acc.
module bip_accumulator #(
    parameter int   DATA_W  = 16,
    parameter int   ADDR_W  = 11,
    parameter logic ALU_ADD = 1'b0,
    parameter logic ALU_SUB = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] acc,
    output logic              acc_zero,
    output logic              done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MEM  = 2'd1;
    localparam logic [1:0] S_EXEC = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [4:0] OP_ST   = 5'd1;
    localparam logic [4:0] OP_LD   = 5'd2;
    localparam logic [4:0] OP_LDI  = 5'd3;
    localparam logic [4:0] OP_ADD  = 5'd4;
    localparam logic [4:0] OP_ADDI = 5'd5;
    localparam logic [4:0] OP_SUB  = 5'd6;
    localparam logic [4:0] OP_SUBI = 5'd7;

    logic [1:0]        state;
    logic [4:0]        opc;
    logic [ADDR_W-1:0] opd;
    logic [DATA_W-1:0] imm_sext;

    // Opcodes whose operand comes from data memory and therefore need the MEM cycle.
    function automatic logic is_mem_op(input logic [4:0] op);
        return (op == OP_LD) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

    assign instr_ready = (state == S_IDLE);
    assign imm_sext    = {{(DATA_W-ADDR_W){opd[ADDR_W-1]}}, opd};
    assign alu_a       = acc;
    assign mem_wdata   = acc;
    assign acc_zero    = (acc == '0);
    assign done        = (state == S_DONE);

    always_comb begin
        mem_rd   = (state == S_MEM);
        mem_wr   = (state == S_EXEC) && (opc == OP_ST);
        mem_addr = (state == S_MEM || state == S_EXEC) ? opd : '0;
        alu_b    = '0;
        alu_op   = ALU_ADD;
        if (state == S_EXEC) begin
            alu_b  = is_mem_op(opc) ? mem_rdata : imm_sext;
            alu_op = (opc == OP_SUB || opc == OP_SUBI) ? ALU_SUB : ALU_ADD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            acc   <= '0;
            opc   <= '0;
            opd   <= '0;
        end else begin
            case (state)
                S_IDLE: if (instr_valid && instr_ready) begin
                    opc   <= instr[15:11];
                    opd   <= instr[ADDR_W-1:0];
                    state <= is_mem_op(instr[15:11]) ? S_MEM : S_EXEC;
                end
                S_MEM:  state <= S_EXEC;
                S_EXEC: begin
                    // Loads bypass the ALU; ST, NOP and unknown opcodes leave acc alone.
                    case (opc)
                        OP_LD, OP_LDI:                     acc <= alu_b;
                        OP_ADD, OP_ADDI, OP_SUB, OP_SUBI:  acc <= alu_result;
                        default: ;
                    endcase
                    state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bip_accumulator.sv
// Randomized and directed bench for bip_accumulator with an ALU, sync RAM and
// an instruction-level reference model of the accumulator and memory.
module tb_bip_accumulator;
    localparam int DW = 16;
    localparam int AW = 11;
    localparam int LOGN = 8192;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          instr_valid = 1'b0;
    logic [15:0]   instr = '0;
    logic          instr_ready, alu_op, mem_rd, mem_wr, acc_zero, done;
    logic [DW-1:0] alu_a, alu_b, alu_result, mem_wdata, mem_rdata, acc;
    logic [AW-1:0] mem_addr;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          op_log   [0:LOGN-1];
    logic          rd_log   [0:LOGN-1];
    logic [AW-1:0] addr_log [0:LOGN-1];
    int            acc_cyc[$];
    int            done_cyc[$];
    logic [DW-1:0] done_acc[$];
    int            wr_cnt = 0;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    bit            both_seen = 0;

    logic [DW-1:0] m_acc = '0;
    logic [DW-1:0] m_mem [int];

    bip_accumulator dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .acc(acc), .acc_zero(acc_zero),
        .done(done)
    );

    always #5 clk = ~clk;

    // External 16-bit ALU and synchronous data RAM
    assign alu_result = alu_op ? (alu_a - alu_b) : (alu_a + alu_b);
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
        if (mem_wr) mem[mem_addr] <= mem_wdata;
    end

    // Mid-cycle observer: cycle index of every accept, done and memory strobe
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            op_log[cyc % LOGN]   = alu_op;
            rd_log[cyc % LOGN]   = mem_rd;
            addr_log[cyc % LOGN] = mem_addr;
            if (instr_valid && instr_ready) acc_cyc.push_back(cyc);
            if (done) begin
                done_cyc.push_back(cyc);
                done_acc.push_back(acc);
            end
            if (mem_wr) begin
                wr_cnt++;
                wr_addr = mem_addr;
                wr_data = mem_wdata;
            end
            if (mem_rd && mem_wr) both_seen = 1;
        end
    end

    // Reference: instruction semantics applied directly to acc / memory contents
    task automatic model(input logic [15:0] ins);
        int o   = int'(ins[15:11]);
        int a   = int'(ins[10:0]);
        int imm = (a >= 1024) ? a - 2048 : a;
        case (o)
            1: m_mem[a] = m_acc;
            2: m_acc = m_mem[a];
            3: m_acc = DW'(imm);
            4: m_acc = m_acc + m_mem[a];
            5: m_acc = DW'(int'(m_acc) + imm);
            6: m_acc = m_acc - m_mem[a];
            7: m_acc = DW'(int'(m_acc) - imm);
            default: ;
        endcase
    endtask

    function automatic int exp_lat(input logic [15:0] ins);
        int o = int'(ins[15:11]);
        return (o == 2 || o == 4 || o == 6) ? 3 : 2;
    endfunction

    function automatic logic [15:0] mk(input int o, input int opnd);
        logic [15:0] r;
        r[15:11] = 5'(o);
        r[10:0]  = 11'(opnd);
        return r;
    endfunction

    // Drive one instruction, drop valid after accept, wait for done (bounded)
    task automatic run_instr(input logic [15:0] ins);
        int na = acc_cyc.size();
        int nd = done_cyc.size();
        int t  = 0;
        instr = ins;
        instr_valid = 1'b1;
        while (acc_cyc.size() == na && t < 20) begin @(posedge clk); #1; t++; end
        instr_valid = 1'b0;
        while (done_cyc.size() == nd && t < 40) begin @(posedge clk); #1; t++; end
        if (done_cyc.size() == nd || acc_cyc.size() == na) begin
            checks++; fails++;
            $display("FAIL run_instr_timeout instr=%h: no accept/done within bound", ins);
            acc_cyc.push_back(-100);
            done_cyc.push_back(-100);
            done_acc.push_back('x);
        end
    endtask

    task automatic test_reset();
        int nd, nw;
        checks++;
        if ({instr_ready, acc_zero, done, mem_rd, mem_wr, alu_op} !== 6'b110000 ||
            acc !== '0 || mem_addr !== '0 || alu_b !== '0) begin
            fails++;
            $display("FAIL reset_state: ready=%b zero=%b done=%b rd=%b wr=%b op=%b acc=%h addr=%h b=%h, required 1 1 0 0 0 0 0 0 0",
                     instr_ready, acc_zero, done, mem_rd, mem_wr, alu_op, acc, mem_addr, alu_b);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        run_instr(mk(3, 16'h055));
        nd = done_cyc.size();
        nw = wr_cnt;
        instr = mk(1, 16'h030);
        instr_valid = 1'b1;
        while (acc_cyc.size() == nd) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (wr_cnt !== nw || done_cyc.size() != nd) begin
            fails++;
            $display("FAIL reset_abort: wr pulses=%0d dones=%0d, required %0d %0d", wr_cnt - nw, done_cyc.size() - nd, 0, 0);
        end
        checks++;
        if (acc !== '0 || instr_ready !== 1'b1 || acc_zero !== 1'b1) begin
            fails++;
            $display("FAIL reset_midop_state: acc=%h ready=%b zero=%b, required 0000 1 1", acc, instr_ready, acc_zero);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        m_acc = '0;
    endtask

    task automatic test_imm();
        logic [15:0] seq [2];
        seq[0] = mk(3, 5);
        seq[1] = mk(5, 3);
        for (int i = 0; i < 2; i++) begin
            run_instr(seq[i]);
            model(seq[i]);
            checks++;
            if (done_acc[$] !== m_acc || done_cyc[$] - acc_cyc[$] != 2) begin
                fails++;
                $display("FAIL imm_%0d: acc=%h lat=%0d, required %h 2", i, done_acc[$], done_cyc[$] - acc_cyc[$], m_acc);
            end
        end
        checks++;
        if (op_log[(acc_cyc[$] + 1) % LOGN] !== 1'b0) begin
            fails++;
            $display("FAIL addi_alu_op: got %b, required 0", op_log[(acc_cyc[$] + 1) % LOGN]);
        end
    endtask

    task automatic test_sub();
        logic [15:0] seq [3];
        logic [15:0] req [3];
        seq[0] = mk(3, 5);     req[0] = 16'h0005;
        seq[1] = mk(7, 'h7FF); req[1] = 16'h0006;
        seq[2] = mk(7, 6);     req[2] = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            run_instr(seq[i]);
            model(seq[i]);
            checks++;
            if (done_acc[$] !== req[i] || done_acc[$] !== m_acc) begin
                fails++;
                $display("FAIL sub_%0d: acc=%h, required %h", i, done_acc[$], req[i]);
            end
        end
        checks++;
        if (op_log[(acc_cyc[$] + 1) % LOGN] !== 1'b1 || acc_zero !== 1'b1) begin
            fails++;
            $display("FAIL subi_op_zero: alu_op=%b acc_zero=%b, required 1 1", op_log[(acc_cyc[$] + 1) % LOGN], acc_zero);
        end
    endtask

    task automatic test_mem_add();
        int a;
        run_instr(mk(3, 'h7FF)); model(mk(3, 'h7FF));
        run_instr(mk(1, 'h010)); model(mk(1, 'h010));
        run_instr(mk(3, 1));     model(mk(3, 1));
        run_instr(mk(4, 'h010)); model(mk(4, 'h010));
        a = acc_cyc[$];
        checks++;
        if (rd_log[(a + 1) % LOGN] !== 1'b1 || addr_log[(a + 1) % LOGN] !== 11'h010) begin
            fails++;
            $display("FAIL add_mem_read: rd=%b addr=%h, required 1 010", rd_log[(a + 1) % LOGN], addr_log[(a + 1) % LOGN]);
        end
        checks++;
        if (done_acc[$] !== 16'h0000 || done_acc[$] !== m_acc || done_cyc[$] - a != 3) begin
            fails++;
            $display("FAIL add_wrap: acc=%h lat=%0d, required 0000 3", done_acc[$], done_cyc[$] - a);
        end
    endtask

    task automatic test_store_load();
        int nw;
        run_instr(mk(3, 'h123)); model(mk(3, 'h123));
        nw = wr_cnt;
        run_instr(mk(1, 'h020)); model(mk(1, 'h020));
        checks++;
        if (wr_cnt - nw != 1 || wr_addr !== 11'h020 || wr_data !== 16'h0123 || done_cyc[$] - acc_cyc[$] != 2) begin
            fails++;
            $display("FAIL store: pulses=%0d addr=%h data=%h lat=%0d, required 1 020 0123 2",
                     wr_cnt - nw, wr_addr, wr_data, done_cyc[$] - acc_cyc[$]);
        end
        run_instr(mk(3, 0)); model(mk(3, 0));
        run_instr(mk(2, 'h020)); model(mk(2, 'h020));
        checks++;
        if (done_acc[$] !== 16'h0123 || done_cyc[$] - acc_cyc[$] != 3) begin
            fails++;
            $display("FAIL load: acc=%h lat=%0d, required 0123 3", done_acc[$], done_cyc[$] - acc_cyc[$]);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] seq [7];
        logic [15:0] req [7];
        int ba = acc_cyc.size();
        int bd = done_cyc.size();
        int i  = 0;
        int t  = 0;
        seq[0] = mk(3, 'h040); seq[1] = mk(31, 'h5A5); seq[2] = mk(1, 'h011);
        seq[3] = mk(5, 'h7FE); seq[4] = mk(0, 0);      seq[5] = mk(4, 'h011);
        seq[6] = mk(6, 'h011);
        for (int k = 0; k < 7; k++) begin model(seq[k]); req[k] = m_acc; end
        instr = seq[0];
        instr_valid = 1'b1;
        while (done_cyc.size() < bd + 7 && t < 100) begin
            @(posedge clk); #1; t++;
            if (acc_cyc.size() > ba + i) begin
                i++;
                if (i < 7) instr = seq[i];
                else instr_valid = 1'b0;
            end
        end
        instr_valid = 1'b0;
        checks++;
        if (done_cyc.size() != bd + 7 || acc_cyc.size() != ba + 7) begin
            fails++;
            $display("FAIL b2b_count: accepts=%0d dones=%0d, required 7 7", acc_cyc.size() - ba, done_cyc.size() - bd);
        end else begin
            for (int k = 0; k < 7; k++) begin
                checks++;
                if (done_acc[bd + k] !== req[k]) begin
                    fails++;
                    $display("FAIL b2b_acc_%0d: acc=%h, required %h", k, done_acc[bd + k], req[k]);
                end
                if (k < 6) begin
                    checks++;
                    if (acc_cyc[ba + k + 1] - acc_cyc[ba + k] != exp_lat(seq[k]) + 1) begin
                        fails++;
                        $display("FAIL b2b_spacing_%0d: got %0d, required %0d", k,
                                 acc_cyc[ba + k + 1] - acc_cyc[ba + k], exp_lat(seq[k]) + 1);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] ins;
        int r, o, bad = 0;
        for (int k = 0; k < 8; k++) begin
            ins = mk(3, $urandom_range(0, 2047)); run_instr(ins); model(ins);
            ins = mk(1, 'h040 + k);               run_instr(ins); model(ins);
        end
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            o = (r < 8) ? r : $urandom_range(8, 31);
            if (o == 1 || o == 2 || o == 4 || o == 6) ins = mk(o, 'h040 + $urandom_range(0, 7));
            else ins = mk(o, $urandom_range(0, 2047));
            run_instr(ins);
            model(ins);
            checks++;
            if (done_acc[$] !== m_acc || done_cyc[$] - acc_cyc[$] != exp_lat(ins)) begin
                fails++;
                bad++;
                if (bad < 10)
                    $display("FAIL random_%0d instr=%h: acc=%h lat=%0d, required %h %0d", n, ins,
                             done_acc[$], done_cyc[$] - acc_cyc[$], m_acc, exp_lat(ins));
            end
        end
        checks++;
        if (acc_zero !== (m_acc == '0)) begin
            fails++;
            $display("FAIL random_acc_zero: got %b, required %b", acc_zero, (m_acc == '0));
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_imm();
        test_sub();
        test_mem_add();
        test_store_load();
        test_back_to_back();
        test_random();
        checks++;
        if (both_seen) begin
            fails++;
            $display("FAIL rd_wr_exclusive: mem_rd and mem_wr seen high together, required never");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
